// File: rtl/serial_ins_fetch.sv
// Fetch stage: owns pc, reads program memory and serialises each 32-bit word LSB first.
// Optional INS_RTYPE_CHECK_EN drops non R-type words and pulses ins_illegal instead.
module serial_ins_fetch #(
    parameter int              XLEN     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_req,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_valid,
    output logic            ins_bit,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic            ins_first,
    output logic            ins_last,
    output logic [XLEN-1:0] pc,
    output logic [2:0]      dbg_state
`ifdef INS_RTYPE_CHECK_EN
    ,
    output logic            ins_illegal
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        word_ok;

    assign mem_addr  = pc;
    assign dbg_state = state;
    // shift_reg only changes on load or handshake, so this bit is a register output.
    assign ins_bit   = shift_reg[0];

`ifdef INS_RTYPE_CHECK_EN
    assign word_ok = (mem_rdata[6:0] == 7'b0110011);
`else
    assign word_ok = 1'b1;
`endif

    // Serial handshake: a bit transfers on a rising edge where ins_valid && ins_ready;
    // ins_valid never drops and ins_bit/ins_first/ins_last never change without a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            ins_valid <= 1'b0;
            ins_first <= 1'b0;
            ins_last  <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef INS_RTYPE_CHECK_EN
            ins_illegal <= 1'b0;
`endif
        end else begin
`ifdef INS_RTYPE_CHECK_EN
            ins_illegal <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    mem_req <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (word_ok) begin
                            shift_reg <= mem_rdata;
                            bit_cnt   <= '0;
                            ins_valid <= 1'b1;
                            ins_first <= 1'b1;
                            ins_last  <= 1'b0;
                            state     <= SHIFT;
                        end else begin
`ifdef INS_RTYPE_CHECK_EN
                            ins_illegal <= 1'b1;
`endif
                            state <= NEXT;
                        end
                    end
                end
                SHIFT: begin
                    if (ins_ready) begin
                        shift_reg <= {1'b0, shift_reg[31:1]};
                        ins_first <= 1'b0;
                        if (bit_cnt == 5'd31) begin
                            ins_valid <= 1'b0;
                            ins_last  <= 1'b0;
                            state     <= NEXT;
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            ins_last <= (bit_cnt == 5'd30);
                        end
                    end
                end
                NEXT: begin
                    pc <= pc + XLEN'(PC_STEP);
                    if (run) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ins_fetch.sv
// Bench for serial_ins_fetch: directed frames, expected bits/addresses queued, monitor compares.
module tb_serial_ins_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        ins_bit, ins_valid, ins_first, ins_last;
    logic        ins_ready = 1'b1;
    logic [31:0] pc;
    logic [2:0]  dbg_state;
`ifdef INS_RTYPE_CHECK_EN
    logic        ins_illegal;
    logic        ins_illegal2;
`endif

    // second instance starting near the top of the address space
    logic        run2 = 1'b0;
    logic [31:0] mem_addr2, pc2;
    logic        mem_req2, mem_valid2 = 1'b0;
    logic        ins_bit2, ins_valid2, ins_first2, ins_last2;
    logic [2:0]  dbg_state2;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    logic [31:0] rx_word = '0;
    logic [2:0]  exp_q[$];
    logic [31:0] addr_q[$];
    int          req_cyc[$];

    serial_ins_fetch dut (
        .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .ins_bit(ins_bit), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_first(ins_first), .ins_last(ins_last), .pc(pc),
        .dbg_state(dbg_state)
`ifdef INS_RTYPE_CHECK_EN
        , .ins_illegal(ins_illegal)
`endif
    );

    serial_ins_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .run(run2), .mem_addr(mem_addr2), .mem_req(mem_req2),
        .mem_rdata(32'h00B5_0533), .mem_valid(mem_valid2), .ins_bit(ins_bit2),
        .ins_valid(ins_valid2), .ins_ready(1'b1), .ins_first(ins_first2), .ins_last(ins_last2),
        .pc(pc2), .dbg_state(dbg_state2)
`ifdef INS_RTYPE_CHECK_EN
        , .ins_illegal(ins_illegal2)
`endif
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // memory for dut2: answers one cycle after each request
    initial begin
        logic f;
        forever begin
            @(negedge clk);
            f = mem_req2;
            @(posedge clk);
            #1 mem_valid2 = f;
        end
    end

    // monitor: pops the scoreboard on every request and every accepted bit
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (mem_req) begin
                req_cyc.push_back(cyc);
                if (addr_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    logic [31:0] ea;
                    ea = addr_q.pop_front();
                    chk("mem_addr", mem_addr, ea);
                    chk("pc_at_req", pc, ea);
                end
            end
            if (ins_valid && ins_ready) begin
                acc_cnt++;
                rx_word = {ins_bit, rx_word[31:1]};
                if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
                else chk("ins_first_last_bit", {29'd0, ins_first, ins_last, ins_bit}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic frame(input logic [31:0] w, input logic [31:0] a, input int d,
                         input int stall_at, input int stall_len, input bit spur,
                         input int abort_at, input bit keep_run, input bit illegal);
        int  base;
        bit  got, spur_done;
        addr_q.push_back(a);
        if (!illegal)
            for (int i = 0; i < 32; i++) exp_q.push_back({(i == 0), (i == 31), w[i]});
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = mem_req;
        end
        chk("req_seen", {31'd0, got}, 1);
        run = keep_run;
        for (int i = 1; i < d; i++) begin
            @(posedge clk);
            #1 chk("no_valid_in_wait", {31'd0, ins_valid}, 0);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = w;
        base = acc_cnt;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_rdata = '0;
        if (illegal) begin
`ifdef INS_RTYPE_CHECK_EN
            chk("illegal_pulse", {31'd0, ins_illegal}, 1);
            chk("illegal_no_valid", {31'd0, ins_valid}, 0);
            @(posedge clk);
            #1;
            chk("illegal_one_cycle", {31'd0, ins_illegal}, 0);
            chk("illegal_no_valid2", {31'd0, ins_valid}, 0);
`endif
            return;
        end
        spur_done = 1'b0;
        for (int n = 0; n < 200 && (acc_cnt - base) < 32; n++) begin
            if (abort_at >= 0 && (acc_cnt - base) == abort_at) begin
                reset = 1'b1;
                run = 1'b0;
                mem_valid = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                reset = 1'b0;
                mem_valid = 1'b0;
                mem_rdata = '0;
                exp_q.delete();
                @(negedge clk);
                chk("abort_valid", {31'd0, ins_valid}, 0);
                chk("abort_pc", pc, 0);
                chk("abort_state", {29'd0, dbg_state}, 0);
                chk("abort_first", {31'd0, ins_first}, 0);
                return;
            end
            if (spur && !spur_done && (acc_cnt - base) == 3) begin
                spur_done = 1'b1;
                mem_valid = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                mem_rdata = '0;
            end
            if (stall_len > 0 && (acc_cnt - base) == stall_at) begin
                ins_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    chk("stall_valid", {31'd0, ins_valid}, 1);
                    chk("stall_bit", {31'd0, ins_bit}, {31'd0, w[stall_at]});
                    chk("stall_flags", {30'd0, ins_first, ins_last}, 0);
                    @(posedge clk);
                    #1;
                end
                ins_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("frame_len", acc_cnt - base, 32);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_ins_valid", {31'd0, ins_valid}, 0);
        chk("rst_ins_bit", {31'd0, ins_bit}, 0);
        chk("rst_first_last", {30'd0, ins_first, ins_last}, 0);
        chk("rst_state", {29'd0, dbg_state}, 0);
        chk("rst_pc2", pc2, 32'hFFFF_FFFC);

        @(posedge clk);
        #1 run = 1'b1;
        frame(32'h00B5_0533, 32'h0, 1, -1, 0, 1'b0, -1, 1'b1, 1'b0);
        chk("rx_word_1", rx_word, 32'h00B5_0533);
        frame(32'h00B5_0533, 32'h4, 1, 7, 5, 1'b0, -1, 1'b1, 1'b0);
        chk("rx_word_2", rx_word, 32'h00B5_0533);
        if (req_cyc.size() >= 2) chk("req_period", req_cyc[1] - req_cyc[0], 35);
        else chk("req_period_seen", req_cyc.size(), 2);
        frame(32'h8000_0001, 32'h8, 10, -1, 0, 1'b1, -1, 1'b1, 1'b0);
        chk("rx_word_3", rx_word, 32'h8000_0001);
        frame(32'h00B5_0533, 32'hC, 1, -1, 0, 1'b0, 15, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1 chk("idle_after_reset", {29'd0, dbg_state}, 0);
        run = 1'b1;
        frame(32'h00B5_0533, 32'h0, 1, -1, 0, 1'b0, -1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("stop_state", {29'd0, dbg_state}, 0);
        chk("stop_pc", pc, 32'h4);

`ifdef INS_RTYPE_CHECK_EN
        run = 1'b1;
        frame(32'h0000_0013, 32'h4, 1, -1, 0, 1'b0, -1, 1'b1, 1'b1);
        frame(32'h40B5_0533, 32'h8, 1, -1, 0, 1'b0, -1, 1'b0, 1'b0);
        chk("rx_word_rtype", rx_word, 32'h40B5_0533);
        repeat (3) @(posedge clk);
        #1 chk("pc_after_illegal", pc, 32'hC);
`endif

        // wrap test on the second instance
        run2 = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = mem_req2;
        end
        chk("req2_seen", {31'd0, got}, 1);
        chk("mem_addr2_top", mem_addr2, 32'hFFFF_FFFC);
        run2 = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = (dbg_state2 == 3'd0);
        end
        chk("dut2_idle", {31'd0, got}, 1);
        chk("pc2_wrap", pc2, 32'h0);
        chk("mem_addr2_wrap", mem_addr2, 32'h0);

        repeat (3) @(posedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
